// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift op codes and requester ids shared by the arbiter and its bench
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// rtl/shift_arbiter_shifter.sv - combinational barrel shifter (LSL/LSR/ASR/ROR)
module shift_arbiter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       control,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] OUT
);

    localparam int SW = $clog2(WIDTH) + 1;

    logic [SW-1:0] inv_amt;

    // shamt 0 gives inv_amt == WIDTH, so the left half of the rotate contributes nothing
    assign inv_amt = SW'(WIDTH) - SW'(shamt);

    always_comb begin
        OUT = DATA;
        case (control)
            SH_LSL:  OUT = DATA << shamt;
            SH_LSR:  OUT = DATA >> shamt;
            SH_ASR:  OUT = $signed(DATA) >>> shamt;
            SH_ROR:  OUT = (DATA >> shamt) | (DATA << inv_amt);
            default: OUT = DATA;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin share of one barrel shifter between two requesters
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_ctrl,
    input  logic [4:0]       req0_shamt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_ctrl,
    input  logic [4:0]       req1_shamt,
    input  logic [WIDTH-1:0] req1_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    logic             ptr;
    logic             free;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             sel;
    logic [1:0]       sel_ctrl;
    logic [4:0]       sel_shamt;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] shift_out;

    assign free   = !rsp_valid || rsp_ready;
    assign grant0 = req0_valid && (!req1_valid || (ptr == REQ0));
    assign grant1 = req1_valid && (!req0_valid || (ptr == REQ1));

    // readies fall with reset because rsp_valid alone cannot block them
    assign req0_ready = reset_n && free && grant0;
    assign req1_ready = reset_n && free && grant1;
    assign accept     = req0_ready || req1_ready;
    assign sel        = grant1 ? REQ1 : REQ0;

    assign sel_ctrl  = (sel == REQ1) ? req1_ctrl  : req0_ctrl;
    assign sel_shamt = (sel == REQ1) ? req1_shamt : req0_shamt;
    assign sel_data  = (sel == REQ1) ? req1_data  : req0_data;

    shift_arbiter_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .control(sel_ctrl),
        .shamt  (sel_shamt),
        .DATA   (sel_data),
        .OUT    (shift_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= REQ0;
            rsp_data  <= '0;
            ptr       <= REQ0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= sel;
            rsp_data  <= shift_out;
            ptr       <= ~sel;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed and randomized self-checking bench for shift_arbiter
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_ctrl = '0, req1_ctrl = '0;
    logic [4:0]   req0_shamt = '0, req1_shamt = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W-1:0] rsp_data;

    int n_cmp = 0;
    int n_fail = 0;
    string phase = "init";

    bit           m_ptr = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_id = 1'b0;
    logic [W-1:0] m_data = '0;

    bit acc0, acc1;

    shift_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_ctrl (req0_ctrl),
        .req0_shamt(req0_shamt),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_ctrl (req1_ctrl),
        .req1_shamt(req1_shamt),
        .req1_data (req1_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // Shift results from integer arithmetic: multiply/divide by 2^s, floor division for ASR.
    function automatic logic [W-1:0] ref_shift(logic [1:0] op, int s, logic [W-1:0] d);
        longint unsigned p  = 64'd1 << s;
        longint unsigned ud = {32'd0, d};
        longint          v;
        case (op)
            2'd0: return 32'(ud * p);
            2'd1: return 32'(ud / p);
            2'd2: begin
                v = d[W-1] ? (longint'(ud) - (64'sd1 <<< 32)) : longint'(ud);
                if (v < 0) v = (v - longint'(p) + 1) / longint'(p);
                else       v = v / longint'(p);
                return 32'(v);
            end
            default: return 32'(ud / p + (ud % p) * ((64'd1 << 32) / p));
        endcase
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s_%s: observed %h expected %h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 1'b0;
        m_valid = 1'b0;
        m_id = 1'b0;
        m_data = '0;
    endtask

    // Called just after a rising edge with inputs already driven; runs one clock.
    task automatic step(output bit a0, output bit a1);
        bit free, g0, g1;
        free = !m_valid || rsp_ready;
        g0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
        g1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
        a0 = free && g0;
        a1 = free && g1;
        #2;
        chk("ready0", 32'(req0_ready), 32'(a0));
        chk("ready1", 32'(req1_ready), 32'(a1));
        @(posedge clk);
        #1;
        if (a0 || a1) begin
            m_valid = 1'b1;
            m_id    = a1;
            m_data  = a1 ? ref_shift(req1_ctrl, int'(req1_shamt), req1_data)
                         : ref_shift(req0_ctrl, int'(req0_shamt), req0_data);
            m_ptr   = !a1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", rsp_data, m_data);
    endtask

    initial begin
        // reset state, requester already asserting valid
        phase = "reset";
        req0_valid = 1'b1;
        #12;
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_id", 32'(rsp_id), 32'd0);
        chk("rsp_data", rsp_data, 32'd0);
        chk("ready0", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        phase = "lsl";
        req0_valid = 1'b1; req0_ctrl = SH_LSL; req0_shamt = 5'd4; req0_data = 32'h0000_0001;
        step(acc0, acc1);
        chk("const", rsp_data, 32'h0000_0010);

        // async reset mid-cycle while a result is held and the pointer favours req1
        phase = "async_rst";
        req0_valid = 1'b1; req0_ctrl = SH_ASR; req0_shamt = 5'd31; req0_data = 32'h8000_0000;
        req1_valid = 1'b1; req1_ctrl = SH_ROR; req1_shamt = 5'd4;  req1_data = 32'h0000_00F1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ready0", 32'(req0_ready), 32'd0);
        chk("ready1", 32'(req1_ready), 32'd0);
        #1;
        reset_n = 1'b1;
        model_reset();

        phase = "fair";
        for (int i = 0; i < 4; i++) begin
            step(acc0, acc1);
            chk("id_seq", 32'(rsp_id), 32'(i % 2));
            chk("data_seq", rsp_data, (i % 2) ? 32'h1000_000F : 32'hFFFF_FFFF);
        end

        phase = "backpressure";
        req0_valid = 1'b0;
        req1_ctrl = SH_LSR; req1_shamt = 5'd28; req1_data = 32'hF000_0000;
        step(acc0, acc1);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = SH_LSL; req0_shamt = 5'd1; req0_data = 32'h0000_0003;
        req1_ctrl = SH_ROR; req1_shamt = 5'd8; req1_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step(acc0, acc1);
            chk("held", rsp_data, 32'h0000_000F);
        end
        rsp_ready = 1'b1;
        step(acc0, acc1);
        chk("resume_acc", 32'(acc0), 32'd1);
        chk("resume_data", rsp_data, 32'h0000_0006);

        phase = "shamt0";
        req1_valid = 1'b0;
        for (int op = 0; op < 4; op++) begin
            req0_valid = 1'b1; req0_ctrl = 2'(op); req0_shamt = 5'd0; req0_data = 32'hA5A5_5A5A;
            step(acc0, acc1);
            chk("const", rsp_data, 32'hA5A5_5A5A);
        end

        phase = "stream1";
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req1_ctrl = 2'($urandom_range(0, 3));
            req1_shamt = 5'($urandom_range(0, 31));
            req1_data = $urandom;
            step(acc0, acc1);
            chk("valid", 32'(rsp_valid), 32'd1);
            chk("id", 32'(rsp_id), 32'd1);
        end

        // random traffic; a requester holds its op until the model says it was taken
        phase = "random";
        acc0 = 1'b1;
        acc1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_ctrl  = 2'($urandom_range(0, 3));
                req0_shamt = 5'($urandom_range(0, 31));
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_ctrl  = 2'($urandom_range(0, 3));
                req1_shamt = 5'($urandom_range(0, 31));
                req1_data  = $urandom;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            step(acc0, acc1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational barrel shifter between two requesters (req0: execute-stage operand-2 path, req1: multi-cycle/auxiliary shift path).
- Round-robin arbitration, valid/ready handshake on both request channels and on one shared response channel.
- One registered response stage; holds its result under back-pressure.
- Sits beside the execute stage; the hazard unit sees only valid/ready.

Parameters:
- WIDTH, 32, data width of operands and result.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req0_valid, input, 1, requester 0 presents an operation.
- req0_ready, output, 1, requester 0 operation accepted this cycle when valid&ready.
- req0_ctrl, input, 2, shift op: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- req0_shamt, input, 5, shift amount 0..31.
- req0_data, input, WIDTH, operand.
- req1_valid / req1_ready / req1_ctrl / req1_shamt / req1_data: same as requester 0.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer accepts result.
- rsp_id, output, 1, index of the requester that owns the result.
- rsp_data, output, WIDTH, shifted result.

Behaviour:
- Reset (asynchronous, reset_n low): rsp_valid=0, rsp_id=0, rsp_data=0, priority pointer=0 (requester 0 favoured). req*_ready are combinational, so they are 0 while reset is asserted.
- Reset mid-operation: any held or in-flight result is discarded. There is no replay.
- Stage-free condition: free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - Both valid: the pointer side wins.
  - Otherwise the sole valid requester wins.
  - reqN_ready = free & grantN. At most one ready is high per cycle; the loser's ready is 0.
- Accept edge (valid&ready on requester N):
  - Shifter is driven from the granted request.
  - Next cycle: rsp_data = shift result, rsp_id = N, rsp_valid = 1.
  - Latency 1 cycle; throughput 1 op/cycle when rsp_ready is held high.
- Pointer: after each accept, pointer = 1 - granted index. It is unchanged on cycles with no accept.
- Back-pressure: while rsp_valid & !rsp_ready, rsp_data and rsp_id hold and both readies are 0.
- Simultaneous pop and accept (rsp_valid & rsp_ready & new accept): new result replaces old on the same edge. rsp_valid stays 1 (no bubble).
- Pop with no accept: rsp_valid -> 0. rsp_data holds its last value.
- Shift semantics (shamt 0 returns operand unchanged for all ops):
  - LSL: zero fill.
  - LSR: zero fill.
  - ASR: sign fill from bit WIDTH-1.
  - ROR: bits shifted out of LSB re-enter at MSB.
- Requesters must hold ctrl/shamt/data stable while valid and not ready. The arbiter does not register them before the grant.
- Fairness: with both valid continuously and rsp_ready=1, grants alternate 0,1,0,1...

Decomposition:
- Shared package shift_pkg:
  - op codes SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - requester id constants REQ0=1'b0, REQ1=1'b1.
- One sub-module: the existing shifter (ports control, shamt, DATA, OUT) instantiated once, fed by the grant mux.
- Arbiter, pointer and response register are in shift_arbiter.

Test Plan:
- Reset then req0 only, LSL, data 0x0000_0001, shamt 4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data 0x0000_0010.
- Both valid every cycle with rsp_ready=1:
  - req0 is ASR of 0x8000_0000 by 31; req1 is ROR of 0x0000_00F1 by 4.
  - Required: rsp_id sequence 0,1,0,1; rsp_data 0xFFFF_FFFF (req0) and 0x1000_000F (req1).
- Back-pressure:
  - req1 LSR of 0xF000_0000 by 28 accepted; rsp_ready low for 3 cycles.
  - Required: rsp_data 0x0000_000F held; req0_ready and req1_ready both 0.
  - After rsp_ready high: the next accept happens in the same cycle.
- shamt 0 on all four ops with data 0xA5A5_5A5A -> each response equals 0xA5A5_5A5A.
- reset_n pulsed low asynchronously mid-cycle while rsp_valid=1 -> rsp_valid drops immediately; the next grant with both valid goes to req0.
- Continuous single-requester stream (req1, 8 ops, rsp_ready=1) -> 8 responses on consecutive cycles, no bubbles, all rsp_id=1.
